mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage. It consumes the registered execute outputs and performs data-memory loads and stores over a valid/ready request and response bus. It aligns, sign-extends or zero-extends load data and selects the write-back value. It registers the result for write-back and asserts a stall back to the upstream stages while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_align.sv | 69 ++++++
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath width, funct3 access
// encodings and the access state machine encoding.
package mem_stage_pkg;

    localparam int XLEN = 64;

    // Load/store funct3 encodings (size in [1:0], unsigned flag in [2])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_align.sv
// Combinational data alignment for the memory stage: misalignment check,
// store byte-lane/mask generation and load shift with sign/zero extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic            misalign,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [XLEN-1:0] shifted;

    // Natural-alignment check by access size
    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = off[0];
            2'b10:   misalign = (off[1:0] != 2'b00);
            2'b11:   misalign = (off != 3'b000);
            default: misalign = 1'b0;
        endcase
    end

    // Store data replicated across lanes; mask selects the addressed lanes
    always_comb begin
        wmask = 8'h00;
        wdata = '0;
        case (funct3[1:0])
            2'b00: begin
                wmask = 8'h01 << off;
                wdata = {8{store_data[7:0]}};
            end
            2'b01: begin
                wmask = 8'h03 << off;
                wdata = {4{store_data[15:0]}};
            end
            2'b10: begin
                wmask = 8'h0F << off;
                wdata = {2{store_data[31:0]}};
            end
            default: begin
                wmask = 8'hFF;
                wdata = store_data;
            end
        endcase
    end

    // Shift the addressed bytes down to bit 0, then extend per funct3
    always_comb begin
        shifted   = rdata >> {off, 3'b000};
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    load_data = shifted;
            F3_BU:   load_data = {56'd0, shifted[7:0]};
            F3_HU:   load_data = {48'd0, shifted[15:0]};
            F3_WU:   load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory loads/stores over a valid/ready
// bus, stalls upstream while an access is outstanding, and registers the
// write-back result.
module mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    input  logic [63:0]       exu_pc,
    input  logic [31:0]       exu_instr,
    input  logic [XLEN-1:0]   exu_alu_result,
    input  logic [XLEN-1:0]   exu_snxt_pc,
    input  logic [XLEN-1:0]   exu_data_rs2,
    input  logic [2:0]        exu_funct3,
    input  logic              exu_load_en,
    input  logic              exu_store_en,
    input  logic              exu_wb_alu_en,
    input  logic              exu_wb_spc_en,
    input  logic              exu_wb_en,
    input  logic              exu_ebreak_en,
    input  logic [4:0]        exu_index_rd,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_wen,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [7:0]        dmem_req_wmask,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    output logic              mem_stall,
    output logic              mem_valid,
    output logic              mem_wb_en,
    output logic [4:0]        mem_index_rd,
    output logic [XLEN-1:0]   mem_wb_data,
    output logic              mem_ebreak_en,
    output logic              mem_misalign,
    output logic [63:0]       mem_pc,
    output logic [31:0]       mem_instr
);

    import mem_stage_pkg::*;

    state_t          state;
    logic            misalign;
    logic            ls_misalign;
    logic            mem_op;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_sel;
    logic            unused_wb_alu_en;

    // The ALU result is the default write-back value, so its enable adds no selection
    assign unused_wb_alu_en = exu_wb_alu_en;

    mem_align u_align (
        .funct3     (exu_funct3),
        .off        (exu_alu_result[2:0]),
        .store_data (exu_data_rs2),
        .rdata      (dmem_rsp_rdata),
        .misalign   (misalign),
        .wmask      (dmem_req_wmask),
        .wdata      (dmem_req_wdata),
        .load_data  (load_data)
    );

    assign ls_misalign    = (exu_load_en | exu_store_en) & misalign;
    assign mem_op         = exu_valid & (exu_load_en | exu_store_en) & ~misalign;
    assign dmem_req_valid = (state == REQ);
    assign dmem_req_wen   = exu_store_en;
    assign dmem_req_addr  = {exu_alu_result[ADDR_W-1:3], 3'b000};

    // Write-back value priority: load data, link PC, ALU result; stores and
    // misaligned accesses write back zero
    always_comb begin
        wb_sel = exu_alu_result;
        if (exu_store_en || ls_misalign)
            wb_sel = '0;
        else if (exu_load_en)
            wb_sel = load_data;
        else if (exu_wb_spc_en)
            wb_sel = exu_snxt_pc;
    end

    // Stall while an access is pending; release in the response cycle
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = mem_op;
            REQ:     mem_stall = 1'b1;
            RESP:    mem_stall = ~dmem_rsp_valid;
            default: mem_stall = 1'b0;
        endcase
    end

    // Access state machine with registered write-back outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mem_valid     <= 1'b0;
            mem_wb_en     <= 1'b0;
            mem_index_rd  <= '0;
            mem_wb_data   <= '0;
            mem_ebreak_en <= 1'b0;
            mem_misalign  <= 1'b0;
            mem_pc        <= '0;
            mem_instr     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state     <= REQ;
                        mem_valid <= 1'b0;
                        mem_wb_en <= 1'b0;
                    end else begin
                        mem_valid     <= exu_valid;
                        mem_wb_en     <= exu_valid & exu_wb_en & ~exu_store_en & ~ls_misalign;
                        mem_index_rd  <= exu_index_rd;
                        mem_wb_data   <= wb_sel;
                        mem_ebreak_en <= exu_ebreak_en;
                        mem_misalign  <= exu_valid & ls_misalign;
                        mem_pc        <= exu_pc;
                        mem_instr     <= exu_instr;
                    end
                end
                REQ: begin
                    mem_valid <= 1'b0;
                    if (dmem_req_ready)
                        state <= RESP;
                end
                RESP: begin
                    if (dmem_rsp_valid) begin
                        state         <= IDLE;
                        mem_valid     <= 1'b1;
                        mem_wb_en     <= exu_wb_en & exu_load_en;
                        mem_index_rd  <= exu_index_rd;
                        mem_wb_data   <= wb_sel;
                        mem_ebreak_en <= exu_ebreak_en;
                        mem_misalign  <= 1'b0;
                        mem_pc        <= exu_pc;
                        mem_instr     <= exu_instr;
                    end else begin
                        mem_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table driven through a small bus
// responder, plus hand sequences for same-cycle response and mid-access reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid;
    logic [63:0] exu_pc;
    logic [31:0] exu_instr;
    logic [63:0] exu_alu_result;
    logic [63:0] exu_snxt_pc;
    logic [63:0] exu_data_rs2;
    logic [2:0]  exu_funct3;
    logic        exu_load_en, exu_store_en, exu_wb_alu_en, exu_wb_spc_en;
    logic        exu_wb_en, exu_ebreak_en;
    logic [4:0]  exu_index_rd;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
    logic [63:0] dmem_req_addr, dmem_req_wdata;
    logic [7:0]  dmem_req_wmask;
    logic        dmem_rsp_valid;
    logic [63:0] dmem_rsp_rdata;
    logic        mem_stall, mem_valid, mem_wb_en, mem_ebreak_en, mem_misalign;
    logic [4:0]  mem_index_rd;
    logic [63:0] mem_wb_data, mem_pc;
    logic [31:0] mem_instr;

    int checks = 0;
    int errors = 0;

    mem_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_pc(exu_pc), .exu_instr(exu_instr),
        .exu_alu_result(exu_alu_result), .exu_snxt_pc(exu_snxt_pc),
        .exu_data_rs2(exu_data_rs2), .exu_funct3(exu_funct3),
        .exu_load_en(exu_load_en), .exu_store_en(exu_store_en),
        .exu_wb_alu_en(exu_wb_alu_en), .exu_wb_spc_en(exu_wb_spc_en),
        .exu_wb_en(exu_wb_en), .exu_ebreak_en(exu_ebreak_en),
        .exu_index_rd(exu_index_rd),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_wen(dmem_req_wen), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
        .mem_index_rd(mem_index_rd), .mem_wb_data(mem_wb_data),
        .mem_ebreak_en(mem_ebreak_en), .mem_misalign(mem_misalign),
        .mem_pc(mem_pc), .mem_instr(mem_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  f3;
        logic        ld, st, spc, wb;
        logic [4:0]  rd;
        logic [63:0] addr, snxt, rs2, rdata;
        int          rdy, rsp;
        logic        e_req;
        logic [63:0] e_addr;
        logic [7:0]  e_wmask;
        logic [63:0] e_wdata;
        int          e_stall;
        logic        e_valid, e_wb_en, e_mis;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic ld, input logic st,
                                input logic spc, input logic wb, input logic [4:0] rd,
                                input logic [63:0] addr, input logic [63:0] snxt,
                                input logic [63:0] rs2, input logic [63:0] rdata,
                                input int rdy, input int rsp, input logic e_req,
                                input logic [63:0] e_addr, input logic [7:0] e_wmask,
                                input logic [63:0] e_wdata, input int e_stall,
                                input logic e_wb_en, input logic e_mis,
                                input logic [63:0] e_data);
        vec_t v;
        v.valid = 1'b1; v.f3 = f3; v.ld = ld; v.st = st; v.spc = spc; v.wb = wb;
        v.rd = rd; v.addr = addr; v.snxt = snxt; v.rs2 = rs2; v.rdata = rdata;
        v.rdy = rdy; v.rsp = rsp; v.e_req = e_req; v.e_addr = e_addr;
        v.e_wmask = e_wmask; v.e_wdata = e_wdata; v.e_stall = e_stall;
        v.e_valid = 1'b1; v.e_wb_en = e_wb_en; v.e_mis = e_mis; v.e_data = e_data;
        return v;
    endfunction

    task automatic clear_inputs();
        exu_valid = 0; exu_pc = '0; exu_instr = '0; exu_alu_result = '0;
        exu_snxt_pc = '0; exu_data_rs2 = '0; exu_funct3 = '0;
        exu_load_en = 0; exu_store_en = 0; exu_wb_alu_en = 0; exu_wb_spc_en = 0;
        exu_wb_en = 0; exu_ebreak_en = 0; exu_index_rd = '0;
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = '0;
    endtask

    // Responder: accepts the request after rdy_wait cycles, answers after
    // rsp_wait RESP cycles, counts stall cycles; returns after the result edge
    task automatic run_access(input int rdy_wait, input int rsp_wait, input logic [63:0] rdata,
                              output int stalls, output logic req_seen,
                              output logic [63:0] a, output logic [63:0] wd,
                              output logic [7:0] wm, output logic wen, output logic timeout);
        int   req_cnt = 0;
        int   rsp_cnt = 0;
        logic in_resp = 0;
        logic accept;
        logic done = 0;
        stalls = 0; req_seen = 0; a = '0; wd = '0; wm = '0; wen = 0; timeout = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_resp) begin
                rsp_cnt++;
                dmem_rsp_valid = (rsp_cnt > rsp_wait);
                dmem_rsp_rdata = rdata;
            end
            if (dmem_req_valid) begin
                req_seen = 1; a = dmem_req_addr; wd = dmem_req_wdata;
                wm = dmem_req_wmask; wen = dmem_req_wen;
                req_cnt++;
                dmem_req_ready = (req_cnt > rdy_wait);
            end
            #1;
            accept = dmem_req_valid & dmem_req_ready;
            if (mem_stall) stalls++;
            else done = 1;
            @(posedge clk);
            if (accept) in_resp = 1;
            #1;
            dmem_req_ready = 0;
            dmem_rsp_valid = 0;
            if (done) begin
                timeout = 0;
                break;
            end
        end
    endtask

    initial begin
        int          stalls;
        logic        req_seen, wen, timeout;
        logic [63:0] a, wd;
        logic [7:0]  wm;
        vec_t        v;

        //          f3      ld st sp wb rd  addr                  snxt           rs2                    rdata
        vecs[0]  = mk(3'b000, 0, 0, 0, 1, 5, 64'h1234,             64'h0,          64'h0,                 64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 1, 0, 64'h1234);
        vecs[1]  = mk(3'b000, 0, 1, 0, 0, 0, 64'h8000_0003,        64'h0,          64'hAB,                64'h0,
                      2, 2, 1, 64'h8000_0000, 8'h08, 64'hABAB_ABAB_ABAB_ABAB, 6, 0, 0, 64'h0);
        vecs[2]  = mk(3'b000, 1, 0, 0, 1, 7, 64'h8000_0006,        64'h0,          64'h0,                 64'h0080_0000_0000_0000,
                      0, 0, 1, 64'h8000_0000, 8'h40, 64'h0, 2, 1, 0, 64'hFFFF_FFFF_FFFF_FF80);
        vecs[3]  = mk(3'b100, 1, 0, 0, 1, 7, 64'h8000_0006,        64'h0,          64'h0,                 64'h0080_0000_0000_0000,
                      0, 0, 1, 64'h8000_0000, 8'h40, 64'h0, 2, 1, 0, 64'h80);
        vecs[4]  = mk(3'b010, 1, 0, 0, 1, 3, 64'h8000_0002,        64'h0,          64'h0,                 64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 1, 64'h0);
        vecs[5]  = mk(3'b000, 0, 0, 1, 1, 1, 64'h8000_0100,        64'h8000_0010,  64'h0,                 64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 1, 0, 64'h8000_0010);
        vecs[6]  = mk(3'b001, 0, 1, 0, 0, 0, 64'h8000_0006,        64'h0,          64'h1234_5678_9ABC_DEF0, 64'h0,
                      1, 1, 1, 64'h8000_0000, 8'hC0, 64'hDEF0_DEF0_DEF0_DEF0, 4, 0, 0, 64'h0);
        vecs[7]  = mk(3'b011, 0, 1, 0, 0, 0, 64'h8000_0008,        64'h0,          64'h0123_4567_89AB_CDEF, 64'h0,
                      0, 0, 1, 64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, 2, 0, 0, 64'h0);
        vecs[8]  = mk(3'b001, 1, 0, 0, 1, 8, 64'h8000_0012,        64'h0,          64'h0,                 64'h0000_0000_8001_0000,
                      3, 0, 1, 64'h8000_0010, 8'h0C, 64'h0, 5, 1, 0, 64'hFFFF_FFFF_FFFF_8001);
        vecs[9]  = mk(3'b101, 1, 0, 0, 1, 8, 64'h8000_0012,        64'h0,          64'h0,                 64'h0000_0000_8001_0000,
                      0, 3, 1, 64'h8000_0010, 8'h0C, 64'h0, 5, 1, 0, 64'h8001);
        vecs[10] = mk(3'b010, 1, 0, 0, 1, 10, 64'h8000_0004,       64'h0,          64'h0,                 64'h8000_0000_1234_5678,
                      0, 0, 1, 64'h8000_0000, 8'hF0, 64'h0, 2, 1, 0, 64'hFFFF_FFFF_8000_0000);
        vecs[11] = mk(3'b110, 1, 0, 0, 1, 11, 64'h8000_0004,       64'h0,          64'h0,                 64'h8000_0000_1234_5678,
                      0, 0, 1, 64'h8000_0000, 8'hF0, 64'h0, 2, 1, 0, 64'h0000_0000_8000_0000);
        vecs[12] = mk(3'b011, 1, 0, 0, 1, 12, 64'h8000_0020,       64'h0,          64'h0,                 64'hDEAD_BEEF_CAFE_F00D,
                      0, 0, 1, 64'h8000_0020, 8'hFF, 64'h0, 2, 1, 0, 64'hDEAD_BEEF_CAFE_F00D);
        vecs[13] = mk(3'b011, 0, 1, 0, 0, 0, 64'h8000_0004,        64'h0,          64'h55,                64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 1, 64'h0);
        vecs[14] = mk(3'b000, 0, 0, 0, 1, 13, 64'h55,              64'h0,          64'h0,                 64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 0, 64'h55);
        vecs[14].valid   = 1'b0;
        vecs[14].e_valid = 1'b0;
        vecs[15] = mk(3'b001, 1, 0, 0, 1, 4, 64'h8000_0001,        64'h0,          64'h0,                 64'h0,
                      0, 0, 0, 64'h0, 8'h00, 64'h0, 0, 0, 1, 64'h0);

        // Reset state
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_valid", {63'd0, mem_valid}, 64'd0);
        check("reset mem_wb_en", {63'd0, mem_wb_en}, 64'd0);
        check("reset mem_wb_data", mem_wb_data, 64'd0);
        check("reset dmem_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        check("reset mem_stall", {63'd0, mem_stall}, 64'd0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            exu_valid      = v.valid;
            exu_pc         = 64'h8000_1000 + 64'(i * 4);
            exu_instr      = 32'h0000_0013 + 32'(i << 7);
            exu_alu_result = v.addr;
            exu_snxt_pc    = v.snxt;
            exu_data_rs2   = v.rs2;
            exu_funct3     = v.f3;
            exu_load_en    = v.ld;
            exu_store_en   = v.st;
            exu_wb_spc_en  = v.spc;
            exu_wb_alu_en  = ~v.ld & ~v.st & ~v.spc;
            exu_wb_en      = v.wb;
            exu_ebreak_en  = i[0];
            exu_index_rd   = v.rd;
            run_access(v.rdy, v.rsp, v.rdata, stalls, req_seen, a, wd, wm, wen, timeout);
            check($sformatf("v%0d timeout", i), {63'd0, timeout}, 64'd0);
            check($sformatf("v%0d req_seen", i), {63'd0, req_seen}, {63'd0, v.e_req});
            if (v.e_req) begin
                check($sformatf("v%0d req_addr", i), a, v.e_addr);
                check($sformatf("v%0d req_wmask", i), {56'd0, wm}, {56'd0, v.e_wmask});
                check($sformatf("v%0d req_wen", i), {63'd0, wen}, {63'd0, v.st});
                if (v.st)
                    check($sformatf("v%0d req_wdata", i), wd, v.e_wdata);
            end
            check($sformatf("v%0d stall_cycles", i), 64'(stalls), 64'(v.e_stall));
            check($sformatf("v%0d mem_valid", i), {63'd0, mem_valid}, {63'd0, v.e_valid});
            check($sformatf("v%0d mem_wb_en", i), {63'd0, mem_wb_en}, {63'd0, v.e_wb_en});
            check($sformatf("v%0d mem_wb_data", i), mem_wb_data, v.e_data);
            check($sformatf("v%0d mem_misalign", i), {63'd0, mem_misalign}, {63'd0, v.e_mis});
            check($sformatf("v%0d mem_index_rd", i), {59'd0, mem_index_rd}, {59'd0, v.rd});
            check($sformatf("v%0d mem_pc", i), mem_pc, 64'h8000_1000 + 64'(i * 4));
            check($sformatf("v%0d mem_instr", i), {32'd0, mem_instr}, {32'd0, 32'h0000_0013 + 32'(i << 7)});
            check($sformatf("v%0d mem_ebreak", i), {63'd0, mem_ebreak_en}, {63'd0, i[0]});
        end

        // Response coincident with acceptance must be ignored
        clear_inputs();
        exu_valid = 1; exu_load_en = 1; exu_wb_en = 1; exu_funct3 = 3'b011;
        exu_alu_result = 64'h8000_0040; exu_index_rd = 5'd20;
        @(negedge clk);                       // IDLE, stall
        @(posedge clk); #1;                   // now REQ
        dmem_req_ready = 1; dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h1111_1111_1111_1111;
        @(negedge clk); #1;
        check("same-cycle rsp stall in REQ", {63'd0, mem_stall}, 64'd1);
        @(posedge clk); #1;                   // now RESP
        dmem_req_ready = 0; dmem_rsp_valid = 0;
        @(negedge clk); #1;
        check("same-cycle rsp still stalled", {63'd0, mem_stall}, 64'd1);
        check("bubble mem_valid", {63'd0, mem_valid}, 64'd0);
        dmem_rsp_valid = 1; dmem_rsp_rdata = 64'h2222_3333_4444_5555;
        #1;
        check("late rsp releases stall", {63'd0, mem_stall}, 64'd0);
        @(posedge clk); #1;
        dmem_rsp_valid = 0;
        check("late rsp mem_valid", {63'd0, mem_valid}, 64'd1);
        check("late rsp wb_data", mem_wb_data, 64'h2222_3333_4444_5555);

        // Reset while in RESP, then a stray response
        exu_valid = 1; exu_load_en = 1; exu_wb_en = 1; exu_funct3 = 3'b011;
        exu_alu_result = 64'h8000_0048; exu_index_rd = 5'd21;
        @(negedge clk);
        @(posedge clk); #1;                   // REQ
        dmem_req_ready = 1;
        @(posedge clk); #1;                   // RESP
        dmem_req_ready = 0;
        check("resp state req_valid low", {63'd0, dmem_req_valid}, 64'd0);
        check("resp state stall", {63'd0, mem_stall}, 64'd1);
        rst = 1'b1;
        #1;
        clear_inputs();
        #1;
        check("mid-reset mem_valid", {63'd0, mem_valid}, 64'd0);
        check("mid-reset mem_wb_data", mem_wb_data, 64'd0);
        check("mid-reset mem_stall", {63'd0, mem_stall}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_rsp_valid = 1; dmem_rsp_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk); #1;
        check("stray rsp stall", {63'd0, mem_stall}, 64'd0);
        check("stray rsp req_valid", {63'd0, dmem_req_valid}, 64'd0);
        @(posedge clk); #1;
        dmem_rsp_valid = 0;
        check("stray rsp mem_valid", {63'd0, mem_valid}, 64'd0);
        check("stray rsp mem_wb_en", {63'd0, mem_wb_en}, 64'd0);
        check("stray rsp mem_wb_data", mem_wb_data, 64'd0);
        check("stray rsp mem_index_rd", {59'd0, mem_index_rd}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
